// File: rtl/spi_slave_fnd_rx.sv
// spi_slave_fnd_rx
//   SPI slave receiver on the FND board side. It synchronizes ss/sclk/mosi into
//   the clk domain and frames 16-bit transfers into a 14-bit counter value.
//   While receiving, it returns a status/echo byte pair on miso.
//
// Parameters
//   CLK_DIV_MIN  minimum sclk half-period in clk cycles (checked by assertion only)
//   MAX_VALUE    largest value accepted; larger frames are rejected
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   cpol, cpha   SPI mode, latched at frame start
//   ss           slave select, active low, asynchronous
//   sclk         SPI clock, asynchronous
//   mosi         serial data in, MSB first
//   miso         serial data out, MSB first {err_sticky, 0, value[13:8]}, value[7:0]
//   value        last accepted value
//   value_valid  one-cycle pulse when value updates
//   frame_err    one-cycle pulse when a frame is rejected
//   busy         high while a frame is in progress
module spi_slave_fnd_rx #(
    parameter int unsigned CLK_DIV_MIN = 4,
    parameter int unsigned MAX_VALUE   = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpol,
    input  logic        cpha,
    input  logic        ss,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    output logic [13:0] value,
    output logic        value_valid,
    output logic        frame_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        RX_HI,
        RX_LO,
        WAIT_END,
        ERR
    } state_t;

    // Synchronizers plus a "previous" stage for edge detection. ss resets low so
    // that an ss already low at reset release does not look like a falling edge.
    logic [1:0] ss_sync, sclk_sync, mosi_sync;
    logic       ss_prev, sclk_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_prev   <= 1'b0;
            sclk_prev <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[0], ss};
            sclk_sync <= {sclk_sync[0], sclk};
            mosi_sync <= {mosi_sync[0], mosi};
            ss_prev   <= ss_sync[1];
            sclk_prev <= sclk_sync[1];
        end
    end

    logic ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic lead_edge, trail_edge, sample_edge, shift_edge;

    state_t      state, state_n;
    logic        cpol_l, cpol_n;
    logic        cpha_l, cpha_n;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  rx_sr, rx_n;
    logic [7:0]  hi_byte, hi_n;
    logic [7:0]  lo_byte, lo_n;
    logic [7:0]  tx_sr, tx_n;
    logic [2:0]  tx_cnt, tx_cnt_n;
    logic        miso_r, miso_n;
    logic [13:0] value_n;
    logic        vv_n, fe_n;
    logic        err_sticky, sticky_n;

    logic [7:0]  rx_shift;
    logic [7:0]  tx_load;
    logic [7:0]  eval_lo;
    logic        do_eval, reject;

    assign ss_fall   =  ss_prev   & ~ss_sync[1];
    assign ss_rise   = ~ss_prev   &  ss_sync[1];
    assign sclk_rise = ~sclk_prev &  sclk_sync[1];
    assign sclk_fall =  sclk_prev & ~sclk_sync[1];

    // Leading edge moves sclk away from its idle level (cpol).
    assign lead_edge   = cpol_l ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_l ? sclk_rise : sclk_fall;
    assign sample_edge = cpha_l ? trail_edge : lead_edge;
    assign shift_edge  = cpha_l ? lead_edge  : trail_edge;

    assign rx_shift = {rx_sr[6:0], mosi_sync[1]};

    function automatic logic frame_ok(input logic [7:0] hi, input logic [7:0] lo);
        return (hi[7:6] == 2'b00) && (32'({hi[5:0], lo}) <= MAX_VALUE);
    endfunction

    always_comb begin
        state_n  = state;
        cpol_n   = cpol_l;
        cpha_n   = cpha_l;
        bit_cnt_n = bit_cnt;
        rx_n     = rx_sr;
        hi_n     = hi_byte;
        lo_n     = lo_byte;
        tx_n     = tx_sr;
        tx_cnt_n = tx_cnt;
        miso_n   = miso_r;
        value_n  = value;
        vv_n     = 1'b0;
        fe_n     = 1'b0;
        sticky_n = err_sticky;
        tx_load  = {err_sticky, 1'b0, value[13:8]};
        eval_lo  = lo_byte;
        do_eval  = 1'b0;
        reject   = 1'b0;

        case (state)
            IDLE: begin
                if (ss_fall) begin
                    cpol_n    = cpol;
                    cpha_n    = cpha;
                    bit_cnt_n = '0;
                    state_n   = RX_HI;
                    // cpha=0 has no shift edge before the first sample, so bit 7
                    // goes out immediately and counts as the first bit presented.
                    if (!cpha) begin
                        miso_n   = tx_load[7];
                        tx_n     = {tx_load[6:0], 1'b0};
                        tx_cnt_n = 3'd1;
                    end else begin
                        miso_n   = 1'b0;
                        tx_n     = tx_load;
                        tx_cnt_n = '0;
                    end
                end
            end
            RX_HI: begin
                if (ss_rise) begin
                    reject  = 1'b1;
                    state_n = IDLE;
                end else if (sample_edge) begin
                    rx_n      = rx_shift;
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        hi_n    = rx_shift;
                        state_n = RX_LO;
                    end
                end
            end
            RX_LO: begin
                if (sample_edge) begin
                    rx_n      = rx_shift;
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        lo_n    = rx_shift;
                        state_n = WAIT_END;
                    end
                end
                // A 16th sample coinciding with ss rising completes the frame.
                if (ss_rise) begin
                    state_n = IDLE;
                    if (sample_edge && bit_cnt == 3'd7) begin
                        do_eval = 1'b1;
                        eval_lo = rx_shift;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            WAIT_END: begin
                if (ss_rise) begin
                    state_n = IDLE;
                    if (sample_edge) reject  = 1'b1;
                    else             do_eval = 1'b1;
                end else if (sample_edge) begin
                    state_n = ERR;
                end
            end
            ERR: begin
                if (ss_rise) begin
                    reject  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if ((state inside {RX_HI, RX_LO, WAIT_END}) && shift_edge) begin
            miso_n   = tx_sr[7];
            tx_cnt_n = tx_cnt + 3'd1;
            tx_n     = (tx_cnt == 3'd7) ? value[7:0] : {tx_sr[6:0], 1'b0};
        end

        if (do_eval) begin
            if (frame_ok(hi_byte, eval_lo)) begin
                value_n  = {hi_byte[5:0], eval_lo};
                vv_n     = 1'b1;
                sticky_n = 1'b0;
            end else begin
                reject = 1'b1;
            end
        end

        if (reject) begin
            fe_n     = 1'b1;
            sticky_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cpol_l      <= 1'b0;
            cpha_l      <= 1'b0;
            bit_cnt     <= '0;
            rx_sr       <= '0;
            hi_byte     <= '0;
            lo_byte     <= '0;
            tx_sr       <= '0;
            tx_cnt      <= '0;
            miso_r      <= 1'b0;
            value       <= '0;
            value_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_sticky  <= 1'b0;
        end else begin
            state       <= state_n;
            cpol_l      <= cpol_n;
            cpha_l      <= cpha_n;
            bit_cnt     <= bit_cnt_n;
            rx_sr       <= rx_n;
            hi_byte     <= hi_n;
            lo_byte     <= lo_n;
            tx_sr       <= tx_n;
            tx_cnt      <= tx_cnt_n;
            miso_r      <= miso_n;
            value       <= value_n;
            value_valid <= vv_n;
            frame_err   <= fe_n;
            err_sticky  <= sticky_n;
        end
    end

    assign busy = (state != IDLE);
    assign miso = (state inside {RX_HI, RX_LO, WAIT_END}) ? miso_r : 1'b0;

    // Cycles since the last synchronized sclk edge; synchronizer jitter can
    // shorten an observed half-period by one cycle.
    logic [7:0] sclk_gap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_gap <= '0;
        end else if (sclk_rise || sclk_fall) begin
            sclk_gap <= '0;
        end else if (sclk_gap != 8'hFF) begin
            sclk_gap <= sclk_gap + 8'd1;
        end
    end

    a_sclk_half_period: assert property (@(posedge clk) disable iff (reset)
        (busy && (sclk_rise || sclk_fall)) |-> (32'(sclk_gap) + 32'd2 >= CLK_DIV_MIN));

    a_pulse_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(value_valid && frame_err));

endmodule

// File: tb/tb_spi_slave_fnd_rx.sv
module tb_spi_slave_fnd_rx;

    localparam int unsigned HALF = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpol, cpha, ss, sclk, mosi;
    logic        miso;
    logic [13:0] value;
    logic        value_valid, frame_err, busy;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit          is_err;
        logic [13:0] val;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [13:0] model_value = '0;
    bit          model_sticky = 1'b0;
    logic [13:0] last_value;

    always #5 clk = ~clk;

    spi_slave_fnd_rx #(
        .CLK_DIV_MIN(4),
        .MAX_VALUE  (9999)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpol       (cpol),
        .cpha       (cpha),
        .ss         (ss),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .value      (value),
        .value_valid(value_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    // Scoreboard: every pulse pops one expected outcome.
    always @(negedge clk) begin
        if (!reset) begin
            if (value_valid || frame_err) begin
                vectors++;
                if (value_valid && frame_err) begin
                    miscompares++;
                    $display("FAIL pulse_overlap: value_valid=%b frame_err=%b required one-hot", value_valid, frame_err);
                end else if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_pulse: value_valid=%b frame_err=%b value=%0d required no pulse",
                             value_valid, frame_err, value);
                end else begin
                    e = exp_q.pop_front();
                    if (frame_err !== e.is_err || value !== e.val) begin
                        miscompares++;
                        $display("FAIL frame_outcome: frame_err=%b value=%0d required frame_err=%b value=%0d",
                                 frame_err, value, e.is_err, e.val);
                    end
                end
            end
            if (!value_valid && value !== last_value) begin
                vectors++;
                miscompares++;
                $display("FAIL value_stability: value=%0d changed from %0d without value_valid", value, last_value);
            end
        end
        last_value = value;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    // Master side: sends nbits of `bits` MSB first and captures up to 16 miso bits
    // just before each sample edge.
    task automatic spi_frame(input logic [16:0] bits, input int nbits, input logic pol,
                             input logic pha, input bit raise_ss, output logic [15:0] cap);
        int idx;
        cap = '0;
        @(negedge clk);
        cpol = pol;
        cpha = pha;
        sclk = pol;
        ss   = 1'b1;
        repeat (6) @(negedge clk);
        ss = 1'b0;
        if (!pha) mosi = bits[nbits-1];
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            idx = nbits - 1 - i;
            if (pha) begin
                sclk = ~pol;
                mosi = bits[idx];
                repeat (HALF) @(negedge clk);
                if (i < 16) cap[15-i] = miso;
                sclk = pol;
                repeat (HALF) @(negedge clk);
            end else begin
                if (i < 16) cap[15-i] = miso;
                sclk = ~pol;
                repeat (HALF) @(negedge clk);
                sclk = pol;
                if (i < nbits - 1) mosi = bits[idx-1];
                repeat (HALF) @(negedge clk);
            end
        end
        if (raise_ss) ss = 1'b1;
    endtask

    // Drives one frame, pushing the expected outcome first; returns the captured
    // and expected miso words.
    task automatic do_frame(input logic [16:0] bits, input int nbits, input logic pol,
                            input logic pha, output logic [15:0] cap, output logic [15:0] exp_m);
        bit ok;
        exp_m = {model_sticky, 1'b0, model_value};
        ok = (nbits == 16) && (bits[15:14] == 2'b00) && (bits[13:0] <= 14'd9999);
        if (ok) begin
            model_value  = bits[13:0];
            model_sticky = 1'b0;
        end else begin
            model_sticky = 1'b1;
        end
        exp_q.push_back('{is_err: !ok, val: model_value});
        spi_frame(bits, nbits, pol, pha, 1'b1, cap);
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpol = 1'b0; cpha = 1'b0; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (value !== 14'd0) begin miscompares++; $display("FAIL reset_value: got %0d required 0", value); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b required 0", busy); end
        vectors++; if (miso !== 1'b0) begin miscompares++; $display("FAIL reset_miso: got %b required 0", miso); end
        vectors++; if (value_valid !== 1'b0 || frame_err !== 1'b0) begin
            miscompares++; $display("FAIL reset_pulses: got vv=%b fe=%b required 0 0", value_valid, frame_err);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic_accept();
        logic [15:0] cap, em;
        do_frame(17'h004D2, 16, 1'b0, 1'b0, cap, em);
        vectors++; if (value !== 14'd1234) begin miscompares++; $display("FAIL basic_value: got %0d required 1234", value); end
        vectors++; if (cap !== 16'h0000) begin miscompares++; $display("FAIL basic_miso: got %h required 0000", cap); end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL basic_pending: got %0d outstanding required 0", exp_q.size()); end
    endtask

    task automatic test_modes();
        logic [15:0] cap, em;
        logic [1:0]  mode;
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            do_frame(17'h0270F, 16, mode[1], mode[0], cap, em);
            vectors++; if (value !== 14'd9999) begin miscompares++; $display("FAIL mode%0d_value: got %0d required 9999", m, value); end
            vectors++; if (cap !== em) begin miscompares++; $display("FAIL mode%0d_miso: got %h required %h", m, cap, em); end
            vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL mode%0d_pending: got %0d outstanding required 0", m, exp_q.size()); end
        end
    endtask

    task automatic test_range_reject();
        logic [15:0] cap, em;
        do_frame(17'h02710, 16, 1'b0, 1'b0, cap, em);
        vectors++; if (value !== 14'd9999) begin miscompares++; $display("FAIL range_value: got %0d required 9999", value); end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL range_pending: got %0d outstanding required 0", exp_q.size()); end
        do_frame(17'h004D2, 16, 1'b0, 1'b1, cap, em);
        vectors++; if (cap[15:8] !== 8'hA7) begin miscompares++; $display("FAIL range_sticky_miso: got %h required a7", cap[15:8]); end
        vectors++; if (cap[7:0] !== 8'h0F) begin miscompares++; $display("FAIL range_lo_miso: got %h required 0f", cap[7:0]); end
        vectors++; if (value !== 14'd1234) begin miscompares++; $display("FAIL range_recover: got %0d required 1234", value); end
    endtask

    task automatic test_reserved_bits();
        logic [15:0] cap, em;
        do_frame(17'h044D2, 16, 1'b1, 1'b1, cap, em);
        vectors++; if (value !== 14'd1234) begin miscompares++; $display("FAIL reserved_value: got %0d required 1234", value); end
        vectors++; if (cap !== em) begin miscompares++; $display("FAIL reserved_miso: got %h required %h", cap, em); end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL reserved_pending: got %0d outstanding required 0", exp_q.size()); end
    endtask

    task automatic test_short_long();
        logic [15:0] cap, em;
        do_frame(17'h00ABC, 12, 1'b0, 1'b0, cap, em);
        vectors++; if (value !== 14'd1234) begin miscompares++; $display("FAIL short_value: got %0d required 1234", value); end
        do_frame(17'h0002A, 17, 1'b0, 1'b0, cap, em);
        vectors++; if (value !== 14'd1234) begin miscompares++; $display("FAIL long_value: got %0d required 1234", value); end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL short_long_pending: got %0d outstanding required 0", exp_q.size()); end
        do_frame(17'h00100, 16, 1'b1, 1'b0, cap, em);
        vectors++; if (cap !== 16'h84D2) begin miscompares++; $display("FAIL short_long_miso: got %h required 84d2", cap); end
        vectors++; if (value !== 14'd256) begin miscompares++; $display("FAIL short_long_next: got %0d required 256", value); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] cap, em;
        spi_frame(17'h001FF, 9, 1'b0, 1'b0, 1'b0, cap);
        reset = 1'b1;
        model_value  = '0;
        model_sticky = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (value !== 14'd0) begin miscompares++; $display("FAIL midreset_value: got %0d required 0", value); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b required 0", busy); end
        vectors++; if (miso !== 1'b0) begin miscompares++; $display("FAIL midreset_miso: got %b required 0", miso); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_ss_low_busy: got %b required 0", busy); end
        ss = 1'b1;
        repeat (10) @(negedge clk);
        vectors++; if (value !== 14'd0) begin miscompares++; $display("FAIL midreset_after_value: got %0d required 0", value); end
        do_frame(17'h0002A, 16, 1'b0, 1'b0, cap, em);
        vectors++; if (value !== 14'd42) begin miscompares++; $display("FAIL midreset_next_value: got %0d required 42", value); end
        vectors++; if (cap !== 16'h0000) begin miscompares++; $display("FAIL midreset_next_miso: got %h required 0000", cap); end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL midreset_pending: got %0d outstanding required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic_accept();
        test_modes();
        test_range_reject();
        test_reserved_bits();
        test_short_long();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_slave_fnd_rx.md
# spi_slave_fnd_rx

SPI slave receiver that sits directly downstream of the up-counter SPI master, on the FND board side. It synchronizes the incoming `ss`/`sclk`/`mosi` lines and frames two-byte transfers into a 14-bit counter value for the FND display driver. It also returns a status/echo byte on `miso` so the master's `miso` input carries meaningful data.

## Interface
- `CLK_DIV_MIN`, 4: minimum `sclk` half-period in `clk` cycles that the block guarantees to handle. Documentation and assertion use only; no logic depends on it.
- `MAX_VALUE`, 9999: largest legal received value. Frames carrying a larger value are rejected.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cpol`  in  1  SPI clock idle level. Latched at frame start.
- `cpha`  in  1  SPI clock phase. Latched at frame start.
- `ss`  in  1  slave select, active low. Asynchronous to `clk`.
- `sclk`  in  1  SPI clock. Asynchronous to `clk`.
- `mosi`  in  1  serial data from master, MSB first.
- `miso`  out  1  serial data to master, MSB first. Reset 0.
- `value`  out  14  last accepted counter value. Reset 0.
- `value_valid`  out  1  one-cycle pulse when `value` updates. Reset 0.
- `frame_err`  out  1  one-cycle pulse when a frame is rejected. Reset 0.
- `busy`  out  1  high while a frame is in progress. Reset 0.

## Operation
- **Synchronization:** `ss`, `sclk` and `mosi` each pass through 2 flops, then a third "previous" flop drives edge detection. All decisions use the synchronized versions only.
- **Edge selection:**
  - The leading edge is the `sclk` transition away from `cpol`; the trailing edge is the transition back to `cpol`.
  - Sample edge: leading when `cpha`=0, trailing when `cpha`=1.
  - Shift edge: the opposite edge.
  - Edge-type selection uses the latched `cpol`/`cpha`.
- **Frame format:** exactly 16 bits per `ss`-low window.
  - Byte 0 is the high byte: bits [7:6] must be 0, bits [5:0] become `value`[13:8].
  - Byte 1 becomes `value`[7:0].
- **FSM states:** IDLE, RX_HI, RX_LO, WAIT_END, ERR.
- **IDLE:**
  - On synchronized `ss` falling: latch `cpol`/`cpha`, clear the 3-bit bit counter, load the tx shift register, go to RX_HI.
  - Tx shift register load: {`err_sticky`, 1'b0, `value`[13:8]}, where `err_sticky` is set by any rejected frame and cleared by any accepted frame.
- **RX_HI / RX_LO:**
  - Each sample edge shifts the synchronized `mosi` into the rx shift register and increments the bit counter (wraps 7→0).
  - On the 8th sample, RX_HI stores the high byte and goes to RX_LO.
  - On the 8th sample, RX_LO stores the low byte and goes to WAIT_END.
- **MISO shifting:**
  - Each shift edge presents the next tx bit on `miso`.
  - When `cpha`=0, bit 7 is on `miso` from the `ss` falling detection onward.
  - After byte 0, the tx register reloads with `value`[7:0].
- **WAIT_END:**
  - A further sample edge goes to ERR (overlength).
  - Synchronized `ss` rising: if high byte [7:6]≠0 or the assembled value > `MAX_VALUE`, pulse `frame_err`; otherwise update `value` and pulse `value_valid`. Then go to IDLE.
- **Early end:** synchronized `ss` rising in RX_HI or RX_LO (short frame) pulses `frame_err`, leaves `value` unchanged, and goes to IDLE.
- **ERR:** ignores `sclk`. Synchronized `ss` rising pulses `frame_err` and goes to IDLE.
- **Outputs by state:**
  - `busy` = state ≠ IDLE.
  - `miso` = 0 in IDLE and ERR.
- **Config changes:** `cpol`/`cpha` changes during a frame have no effect until the next frame.

## Timing
- Raw `ss` rising edge to `value_valid`/`frame_err` pulse: 3 or 4 `clk` cycles, depending on sampling phase.
- Raw `sclk` sample edge to the bit being captured: 3 or 4 cycles. `sclk` half-period must be ≥ `CLK_DIV_MIN` cycles.
- `value_valid` and `frame_err` are never high in the same cycle. Each is exactly one cycle wide.
- `value` changes only in the cycle `value_valid` is high. It is stable otherwise.
- **`ss` falling and a `sclk` edge detected in the same cycle:** frame start takes priority and the `sclk` edge is ignored. The master must leave ≥1 half-period between them.
- **`ss` rising and the 16th sample edge detected in the same cycle:** the sample is taken first, then the frame is evaluated as complete.
- **Asynchronous `reset` mid-frame:** all outputs go to reset values immediately and the FSM goes to IDLE. A frame interrupted by reset is neither accepted nor flagged.
- **`ss` already low when `reset` deasserts:** the block waits for a full `ss` high→low transition before receiving.

## Test plan
- **Basic accept:** mode 0, `clk`/`sclk` ratio 10, frame 0x04,0xD2 → `value`=1234 with one `value_valid` pulse. `miso` returns 0x00,0x00 on the first frame.
- **All four modes:** cpol/cpha = 00, 01, 10, 11, each sending 9999 (0x27,0x0F) → `value`=9999 each time and no `frame_err`.
- **Range reject:** frame 0x27,0x10 (10000) → `frame_err` pulse, `value` keeps its previous value, next frame's `miso` byte 0 = 0x80|hi.
- **Reserved bits set:** frame 0x44,0xD2 → `frame_err` pulse, `value` unchanged.
- **Short and long frames:** `ss` rises after 12 bits → `frame_err`. A 17-bit frame → `frame_err`. Neither updates `value`.
- **Reset mid-frame:** `reset` asserted after 9 bits → `value`=0, `busy`=0, no pulses. The following good frame of 42 → `value`=42.
